m6809_bus_arbiter: RTL and testbench
====================================

// Module: m6809_bus_arbiter
// PURPOSE
//  Shares the 6809 SoC memory bus (boot ROM at 0x8000-0xFFFF, RAM at 0x0000-0x7FFF) between the
//  core6809 master and a DMA master. Sequences each access: captures the request, applies the
//  region's wait states, drives the memory strobes, and returns a one-cycle ack with read data.
//  Sits between core6809/DMA and rom_boot/ram in m6809_integration.
// PARAMETERS
//  ROM_WS        1  wait states added to ROM accesses (0..15)
//  RAM_WS        0  wait states added to RAM accesses (0..15)
//  STARVE_LIMIT  8  consecutive cycles a DMA request may lose before it takes priority (1..255)
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  reset_b      in   1   synchronous active-low reset
//  cpu_req      in   1   CPU access request; held until cpu_ack
//  cpu_addr     in  16   CPU address
//  cpu_wdata    in   8   CPU write data
//  cpu_rw_n     in   1   1 = read, 0 = write
//  cpu_ack      out  1   one-cycle completion pulse
//  cpu_rdata    out  8   read data, valid while cpu_ack = 1
//  dma_req/dma_addr/dma_wdata/dma_rw_n/dma_ack/dma_rdata: same as cpu_* for the DMA master
//  mem_addr     out 16   registered address to memories
//  mem_wdata    out  8   registered write data
//  mem_we       out  1   write strobe, one cycle
//  mem_sel_rom  out  1   ROM select; mem_sel_ram = RAM select (out, 1)
//  mem_rdata_rom in  8   ROM read data; mem_rdata_ram (in, 8) RAM read data
//  wp_err       out  1   ROM write-protect violation pulse (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; all acks, mem_we, selects, wp_err = 0; mem_addr, mem_wdata, rdata = 0;
//    starvation counter = 0. Reset mid-access abandons it: no ack, no write strobe.
//  - FSM: IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: if any req, grant one master; latch addr/wdata/rw_n into mem_* regs; decode region
//    (addr[15]=1 ROM else RAM); load wait counter with ROM_WS or RAM_WS; go to ACCESS.
//  - Arbitration: CPU wins ties unless starve_cnt >= STARVE_LIMIT, then DMA wins.
//    starve_cnt increments (saturating) each IDLE cycle dma_req=1 and DMA not granted;
//    clears on DMA grant.
//  - ACCESS: select of decoded region held high; counter decrements each cycle. On the cycle
//    count = 0: mem_we = 1 if write, read data sampled into granted master's rdata reg; go to DONE.
//    ACCESS lasts WS+1 cycles.
//  - DONE: granted master's ack = 1 for exactly one cycle; selects drop; return to IDLE.
//  - Latency: req sampled in IDLE at edge k -> ack high in cycle k+WS+2. Throughput one access
//    per WS+3 cycles. Requester must drop req (or present a new one) in its ack cycle; a held
//    req is treated as a new request in the next IDLE.
//  - Request signals changing after grant are ignored; a req dropped mid-access still gets an ack.
//  - Only one ack asserted at a time; rdata of the non-granted master holds its last value.
//  - Width: counters 4 bit (wait), 8 bit (starve); no wrap: starve saturates at 255.
// CONFIGURATION
//  M6809_ROM_WP_EN defined: writes decoded to ROM suppress mem_we, still complete with ack,
//    and pulse wp_err in the DONE cycle.
//  Not defined: ROM writes assert mem_we like RAM writes (ROM ignores them); wp_err tied 0.
// STRUCTURE
//  Package m6809_bus_pkg: FSM state encoding (IDLE/ACCESS/DONE), master-id constants
//    (MST_CPU, MST_DMA), region constants (ROM base 0x8000, region bit 15).
//  Sub-module m6809_bus_decode: combinational addr -> {sel_rom, sel_ram, wait_states}.
// TESTING
//  1 CPU read 0x0010, RAM_WS=0, RAM[0x10]=0x5A -> cpu_ack at k+2, cpu_rdata=0x5A, mem_we never 1.
//  2 CPU write 0x0020 = 0xC3 -> mem_we exactly one cycle with mem_addr=0x0020, wdata=0xC3; ack k+2.
//  3 CPU read 0x8004, ROM_WS=1 -> mem_sel_rom high 2 cycles, cpu_ack at k+3 with ROM byte.
//  4 CPU and DMA req continuously, STARVE_LIMIT=8 -> DMA granted after 8 losing IDLE cycles,
//    starve_cnt returns 0, next tie goes to CPU.
//  5 reset_b low during ACCESS of a write -> no mem_we, no ack; after release FSM in IDLE, outputs 0.
//  6 M6809_ROM_WP_EN: CPU write 0x9000 -> mem_we stays 0, cpu_ack and wp_err pulse together;
//    macro off -> mem_we pulses, wp_err stays 0.

Source files
------------

// File: rtl/m6809_bus_pkg.sv
// Shared types and constants for the 6809 SoC bus arbiter.
// Contents: FSM state encoding, master ids, region decode constants, decode payload struct.
package m6809_bus_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned WAIT_W     = 4;
    localparam int unsigned STARVE_W   = 8;
    localparam int unsigned REGION_BIT = 15;

    // Boot ROM occupies the upper half of the address space.
    localparam logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(1) << REGION_BIT;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic              sel_rom;
        logic              sel_ram;
        logic [WAIT_W-1:0] wait_states;
    } decode_t;

    function automatic logic is_rom(input logic [ADDR_W-1:0] addr);
        return addr >= ROM_BASE;
    endfunction

endpackage

// File: rtl/m6809_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memories.
// slave modport: arbiter view (requests in, acks/memory strobes out).
// master modport: requester/memory-model view (the mirror image).
interface m6809_bus_arbiter_if;
    import m6809_bus_pkg::*;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rw_n;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_rw_n;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_sel_rom;
    logic              mem_sel_ram;
    logic [DATA_W-1:0] mem_rdata_rom;
    logic [DATA_W-1:0] mem_rdata_ram;
    logic              wp_err;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_rw_n,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_addr, dma_wdata, dma_rw_n,
        output dma_ack, dma_rdata,
        output mem_addr, mem_wdata, mem_we, mem_sel_rom, mem_sel_ram,
        input  mem_rdata_rom, mem_rdata_ram,
        output wp_err
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_rw_n,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_addr, dma_wdata, dma_rw_n,
        input  dma_ack, dma_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_sel_rom, mem_sel_ram,
        output mem_rdata_rom, mem_rdata_ram,
        input  wp_err
    );

endinterface

// File: rtl/m6809_bus_decode.sv
// Combinational address decode: region select and wait states for that region.
// Ports: addr (in) -> dec_c {sel_rom, sel_ram, wait_states} (out, combinational).
module m6809_bus_decode
    import m6809_bus_pkg::*;
#(
    parameter int unsigned ROM_WS = 1,
    parameter int unsigned RAM_WS = 0
) (
    input  logic [ADDR_W-1:0] addr,
    output decode_t           dec_c
);

    always_comb begin
        dec_c = '0;
        if (is_rom(addr)) begin
            dec_c.sel_rom     = 1'b1;
            dec_c.wait_states = WAIT_W'(ROM_WS);
        end else begin
            dec_c.sel_ram     = 1'b1;
            dec_c.wait_states = WAIT_W'(RAM_WS);
        end
    end

endmodule

// File: rtl/m6809_bus_arbiter.sv
// Shares the SoC memory bus between core6809 and DMA: arbitrates, applies region wait
// states, drives registered memory strobes and returns a one-cycle ack with read data.
// Ports: clk, reset_b (synchronous, active low), bus (m6809_bus_arbiter_if.slave).
// Build option: M6809_ROM_WP_EN -- ROM writes are blocked and flagged on wp_err.
module m6809_bus_arbiter
    import m6809_bus_pkg::*;
#(
    parameter int unsigned ROM_WS       = 1,
    parameter int unsigned RAM_WS       = 0,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                  clk,
    input logic                  reset_b,
    m6809_bus_arbiter_if.slave   bus
);

    state_e              state;
    logic                grant;
    logic                rw_n_q;
    logic                wp_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [STARVE_W-1:0] starve_cnt;

    logic                cpu_ack;
    logic                dma_ack;
    logic [DATA_W-1:0]   cpu_rdata;
    logic [DATA_W-1:0]   dma_rdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_we;
    logic                mem_sel_rom;
    logic                mem_sel_ram;
    logic                wp_err;

    // Arbitration: CPU wins ties until the DMA has lost STARVE_LIMIT IDLE cycles.
    logic              dma_win_c;
    logic              any_req_c;
    logic [ADDR_W-1:0] req_addr_c;
    logic [DATA_W-1:0] req_wdata_c;
    logic              req_rw_n_c;
    logic              wp_now_c;
    logic [DATA_W-1:0] read_mux_c;
    decode_t           dec_c;

    assign dma_win_c   = bus.dma_req &&
                         (!bus.cpu_req || (starve_cnt >= STARVE_W'(STARVE_LIMIT)));
    assign any_req_c   = bus.cpu_req || bus.dma_req;
    assign req_addr_c  = dma_win_c ? bus.dma_addr  : bus.cpu_addr;
    assign req_wdata_c = dma_win_c ? bus.dma_wdata : bus.cpu_wdata;
    assign req_rw_n_c  = dma_win_c ? bus.dma_rw_n  : bus.cpu_rw_n;
    assign read_mux_c  = mem_sel_rom ? bus.mem_rdata_rom : bus.mem_rdata_ram;

    m6809_bus_decode #(
        .ROM_WS (ROM_WS),
        .RAM_WS (RAM_WS)
    ) u_decode (
        .addr  (req_addr_c),
        .dec_c (dec_c)
    );

    // A write decoded to ROM is a protection violation only when the feature is built in.
`ifdef M6809_ROM_WP_EN
    assign wp_now_c = dec_c.sel_rom && !req_rw_n_c;
`else
    assign wp_now_c = 1'b0;
`endif

    // Access sequencer: IDLE -> ACCESS (WS+1 cycles) -> DONE (ack) -> IDLE.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state       <= ST_IDLE;
            grant       <= MST_CPU;
            rw_n_q      <= 1'b1;
            wp_q        <= 1'b0;
            wait_cnt    <= '0;
            starve_cnt  <= '0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_sel_rom <= 1'b0;
            mem_sel_ram <= 1'b0;
            wp_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req_c) begin
                        grant       <= dma_win_c ? MST_DMA : MST_CPU;
                        mem_addr    <= req_addr_c;
                        mem_wdata   <= req_wdata_c;
                        rw_n_q      <= req_rw_n_c;
                        wp_q        <= wp_now_c;
                        mem_sel_rom <= dec_c.sel_rom;
                        mem_sel_ram <= dec_c.sel_ram;
                        wait_cnt    <= dec_c.wait_states;
                        // Zero wait states: the strobe cycle is the first ACCESS cycle.
                        mem_we      <= (dec_c.wait_states == '0) && !req_rw_n_c && !wp_now_c;
                        state       <= ST_ACCESS;
                    end
                    if (dma_win_c) begin
                        starve_cnt <= '0;
                    end else if (bus.dma_req && (starve_cnt != '1)) begin
                        starve_cnt <= starve_cnt + STARVE_W'(1);
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        mem_we      <= 1'b0;
                        mem_sel_rom <= 1'b0;
                        mem_sel_ram <= 1'b0;
                        wp_err      <= wp_q;
                        if (grant == MST_DMA) begin
                            dma_ack <= 1'b1;
                            if (rw_n_q) dma_rdata <= read_mux_c;
                        end else begin
                            cpu_ack <= 1'b1;
                            if (rw_n_q) cpu_rdata <= read_mux_c;
                        end
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                        // Raise the strobe so it lands in the cycle the counter reads zero.
                        mem_we   <= (wait_cnt == WAIT_W'(1)) && !rw_n_q && !wp_q;
                    end
                end
                ST_DONE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    wp_err  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack     = cpu_ack;
    assign bus.dma_ack     = dma_ack;
    assign bus.cpu_rdata   = cpu_rdata;
    assign bus.dma_rdata   = dma_rdata;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.mem_we      = mem_we;
    assign bus.mem_sel_rom = mem_sel_rom;
    assign bus.mem_sel_ram = mem_sel_ram;
    assign bus.wp_err      = wp_err;

endmodule

// File: tb/tb_m6809_bus_arbiter.sv
// Scoreboard bench for m6809_bus_arbiter: stimulus pushes expected acks/writes, monitors pop.
module tb_m6809_bus_arbiter;
    import m6809_bus_pkg::*;

    localparam int unsigned ROM_WS       = 1;
    localparam int unsigned RAM_WS       = 0;
    localparam int unsigned STARVE_LIMIT = 8;

    typedef struct {
        logic        is_dma;
        logic        rd;
        logic [7:0]  data;
        logic        wp;
        int unsigned cyc;
        int unsigned sel_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    m6809_bus_arbiter_if bus_if();

    m6809_bus_arbiter #(
        .ROM_WS       (ROM_WS),
        .RAM_WS       (RAM_WS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus_if)
    );

    // Memory models: ROM byte is a fixed function of the address, RAM is 256 bytes mirrored.
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    logic [7:0] ram [256];
    logic       ram_loaded = 1'b0;

    assign bus_if.mem_rdata_rom = rom_byte(bus_if.mem_addr);
    assign bus_if.mem_rdata_ram = ram[bus_if.mem_addr[7:0]];

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[8'h10] <= 8'h5A;
            ram[8'h11] <= 8'h77;
            ram_loaded <= 1'b1;
        end else if (bus_if.mem_we && bus_if.mem_sel_ram) begin
            ram[bus_if.mem_addr[7:0]] <= bus_if.mem_wdata;
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    exp_t        exp_q[$];
    logic [23:0] wr_q[$];

    // Ack / write monitor.
    int unsigned sel_run   = 0;
    logic [7:0]  m_cpu_rd  = 8'h00;
    logic [7:0]  m_dma_rd  = 8'h00;
    logic        m_cpu_ok  = 1'b1;
    logic        m_dma_ok  = 1'b1;

    always @(negedge clk) begin
        exp_t        e;
        logic [23:0] w;
        if (!reset_b) begin
            sel_run  = 0;
            m_cpu_rd = 8'h00;
            m_dma_rd = 8'h00;
            m_cpu_ok = 1'b1;
            m_dma_ok = 1'b1;
        end else begin
            if (bus_if.mem_sel_rom || bus_if.mem_sel_ram) sel_run++;
            if (bus_if.mem_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_mem_we", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    check("we_addr_data", {bus_if.mem_addr, bus_if.mem_wdata}, w);
                end
            end
            if (bus_if.wp_err && !bus_if.cpu_ack && !bus_if.dma_ack)
                check("wp_err_outside_ack", 1, 0);
            if (bus_if.cpu_ack || bus_if.dma_ack) begin
                if (bus_if.cpu_ack && bus_if.dma_ack) check("dual_ack", 1, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_master", bus_if.dma_ack, e.is_dma);
                    check("ack_cycle", cyc, e.cyc);
                    check("sel_cycles", sel_run, e.sel_cycles);
                    check("sel_drop", {bus_if.mem_sel_rom, bus_if.mem_sel_ram}, 0);
                    check("wp_err", bus_if.wp_err, e.wp);
                    if (e.is_dma) begin
                        if (e.rd) check("dma_rdata", bus_if.dma_rdata, e.data);
                        if (m_cpu_ok) check("cpu_rdata_hold", bus_if.cpu_rdata, m_cpu_rd);
                        m_dma_ok = e.rd;
                        if (e.rd) m_dma_rd = e.data;
                    end else begin
                        if (e.rd) check("cpu_rdata", bus_if.cpu_rdata, e.data);
                        if (m_dma_ok) check("dma_rdata_hold", bus_if.dma_rdata, m_dma_rd);
                        m_cpu_ok = e.rd;
                        if (e.rd) m_cpu_rd = e.data;
                    end
                end
                sel_run = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_ack"},   bus_if.cpu_ack,     0);
        check({tag, "_dma_ack"},   bus_if.dma_ack,     0);
        check({tag, "_mem_we"},    bus_if.mem_we,      0);
        check({tag, "_sel"},       {bus_if.mem_sel_rom, bus_if.mem_sel_ram}, 0);
        check({tag, "_wp_err"},    bus_if.wp_err,      0);
        check({tag, "_mem_addr"},  bus_if.mem_addr,    0);
        check({tag, "_mem_wdata"}, bus_if.mem_wdata,   0);
        check({tag, "_rdata"},     {bus_if.cpu_rdata, bus_if.dma_rdata}, 0);
    endtask

    // One access from one master; expected ack lands WS+2 cycles after the issue cycle.
    task automatic do_access(input logic is_dma, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic rw_n, input logic [7:0] exp_rd, input string name);
        exp_t        e;
        int unsigned ws;
        logic        wp;
        logic        got;
        ws = addr[15] ? ROM_WS : RAM_WS;
`ifdef M6809_ROM_WP_EN
        wp = addr[15] && !rw_n;
`else
        wp = 1'b0;
`endif
        @(negedge clk);
        if (is_dma) begin
            bus_if.dma_req = 1'b1; bus_if.dma_addr = addr;
            bus_if.dma_wdata = wdata; bus_if.dma_rw_n = rw_n;
        end else begin
            bus_if.cpu_req = 1'b1; bus_if.cpu_addr = addr;
            bus_if.cpu_wdata = wdata; bus_if.cpu_rw_n = rw_n;
        end
        e.is_dma = is_dma; e.rd = rw_n; e.data = exp_rd; e.wp = wp;
        e.cyc = cyc + ws + 2; e.sel_cycles = ws + 1;
        exp_q.push_back(e);
        if (!rw_n && !wp) wr_q.push_back({addr, wdata});
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = is_dma ? bus_if.dma_ack : bus_if.cpu_ack;
        end
        if (!got) check({name, "_timeout"}, 0, 1);
        bus_if.cpu_req = 1'b0;
        bus_if.dma_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int unsigned base;
        int          n;
        bus_if.cpu_req = 1'b0; bus_if.cpu_addr = '0; bus_if.cpu_wdata = '0; bus_if.cpu_rw_n = 1'b1;
        bus_if.dma_req = 1'b0; bus_if.dma_addr = '0; bus_if.dma_wdata = '0; bus_if.dma_rw_n = 1'b1;
        reset_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_b = 1'b1;

        do_access(1'b0, 16'h0010, 8'h00, 1'b1, 8'h5A, "cpu_rd_ram");
        do_access(1'b0, 16'h0020, 8'hC3, 1'b0, 8'h00, "cpu_wr_ram");
        do_access(1'b0, 16'h0020, 8'h00, 1'b1, 8'hC3, "cpu_rd_back");
        do_access(1'b0, 16'h8004, 8'h00, 1'b1, 8'h38, "cpu_rd_rom");
        do_access(1'b1, 16'h0011, 8'h00, 1'b1, 8'h77, "dma_rd_ram");
        do_access(1'b1, 16'h0040, 8'h1E, 1'b0, 8'h00, "dma_wr_ram");
        do_access(1'b0, 16'h0040, 8'h00, 1'b1, 8'h1E, "cpu_rd_dma_data");
        do_access(1'b0, 16'h9000, 8'hEE, 1'b0, 8'h00, "cpu_wr_rom");
        do_access(1'b0, 16'hFFFF, 8'h00, 1'b1, 8'hC3, "cpu_rd_rom_top");

        // Contention: 8 CPU wins, then the starved DMA, then the CPU again.
        @(negedge clk);
        bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 16'h0010; bus_if.cpu_rw_n = 1'b1;
        bus_if.dma_req = 1'b1; bus_if.dma_addr = 16'h0011; bus_if.dma_rw_n = 1'b1;
        base = cyc;
        for (int i = 0; i < 10; i++) begin
            e.is_dma = (i == 8); e.rd = 1'b1; e.data = (i == 8) ? 8'h77 : 8'h5A;
            e.wp = 1'b0; e.cyc = base + 2 + 3 * i; e.sel_cycles = 1;
            exp_q.push_back(e);
        end
        n = 0;
        for (int t = 0; t < 100 && n < 10; t++) begin
            @(negedge clk);
            if (bus_if.cpu_ack || bus_if.dma_ack) n++;
        end
        bus_if.cpu_req = 1'b0;
        bus_if.dma_req = 1'b0;
        check("contention_acks", n, 10);
        @(negedge clk);

        // Reset in the first ACCESS cycle of a ROM write abandons it.
        bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 16'h9000;
        bus_if.cpu_wdata = 8'h55; bus_if.cpu_rw_n = 1'b0;
        @(negedge clk);
        reset_b = 1'b0;
        bus_if.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("postreset");
        do_access(1'b0, 16'h0010, 8'h00, 1'b1, 8'h5A, "cpu_rd_after_reset");

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
